// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; starts and stops only on frame boundaries.
// Optional macro VGA_TIMING_PIXDIV2_EN: counters advance every other PCLK (PCLK = 2x pixel clock).
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic       vga_en,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       frame_start,
   output logic       busy
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 11-bit bounds so a window ending exactly at a 1024 total does not wrap.
   localparam logic [9:0]  HLast    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);
   localparam logic [10:0] HActEnd  = 11'(H_ACTIVE);
   localparam logic [10:0] VActEnd  = 11'(V_ACTIVE);
   localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VSyncBeg = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e     state_q, state_d;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic       tick;
   logic       last_pix;

   logic       hsync_q, vsync_q, video_on_q, frame_start_q, busy_q;
   logic [9:0] pix_x_q, pix_y_q;

`ifdef VGA_TIMING_PIXDIV2_EN
   logic tick_q;

   // First cycle after leaving idle is a tick so frame_start latency matches the 1x build.
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         tick_q <= 1'b0;
      end else if (state_d == StIdle) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= ~tick_q;
      end
   end

   assign tick = tick_q;
`else
   assign tick = 1'b1;
`endif

   assign last_pix = (hcnt_q == HLast) && (vcnt_q == VLast);

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      vcnt_d  = vcnt_q;
      case (state_q)
         StIdle: begin
            hcnt_d = '0;
            vcnt_d = '0;
            if (vga_en) begin
               state_d = StRun;
            end
         end
         StRun, StDrain: begin
            if (tick) begin
               if (hcnt_q == HLast) begin
                  hcnt_d = '0;
                  vcnt_d = (vcnt_q == VLast) ? 10'd0 : vcnt_q + 10'd1;
               end else begin
                  hcnt_d = hcnt_q + 10'd1;
               end
            end
            if (vga_en) begin
               state_d = StRun;
            end else if (tick && last_pix) begin
               state_d = StIdle;
            end else begin
               state_d = StDrain;
            end
         end
         default: begin
            state_d = StIdle;
            hcnt_d  = '0;
            vcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= StIdle;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
      end
   end

   logic       active;
   logic       vis;
   logic       hs_win, vs_win;
   logic       out_upd;
   logic [10:0] hext, vext;

   assign active  = (state_q != StIdle);
   assign hext    = {1'b0, hcnt_q};
   assign vext    = {1'b0, vcnt_q};
   assign vis     = active && (hext < HActEnd) && (vext < VActEnd);
   assign hs_win  = active && (hext >= HSyncBeg) && (hext < HSyncEnd);
   assign vs_win  = active && (vext >= VSyncBeg) && (vext < VSyncEnd);
   // Idle must refresh outputs too, otherwise busy would stay high when tick is held low.
   assign out_upd = tick || !active;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         hsync_q       <= ~SYNC_POL;
         vsync_q       <= ~SYNC_POL;
         video_on_q    <= 1'b0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else if (out_upd) begin
         hsync_q       <= hs_win ? SYNC_POL : ~SYNC_POL;
         vsync_q       <= vs_win ? SYNC_POL : ~SYNC_POL;
         video_on_q    <= vis;
         pix_x_q       <= vis ? hcnt_q : 10'd0;
         pix_y_q       <= vis ? vcnt_q : 10'd0;
         frame_start_q <= tick && active && (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
         busy_q        <= active;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;

endmodule
